hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-unit encodings: instruction class, operand forward select and
// the per-stage tracking record. The control unit and datapath muxes use these too.
package hazard_pkg;

  // ID-stage instruction class
  typedef enum logic [1:0] {
    OptNone  = 2'b00,
    OptAlu   = 2'b01,
    OptLoad  = 2'b10,
    OptBrJmp = 2'b11
  } optype_e;

  // Operand source select for the EX-stage operand muxes
  typedef enum logic [1:0] {
    FwdRegFile = 2'b00,
    FwdExAlu   = 2'b01,
    FwdMemAlu  = 2'b10,
    FwdMemLoad = 2'b11
  } fwd_sel_e;

  // What the hazard unit remembers about an in-flight instruction
  typedef struct packed {
    logic    valid;
    logic [4:0] rd;
    optype_e optype;
  } track_rec_t;

  localparam track_rec_t TrackRecIdle = '{valid: 1'b0, rd: 5'd0, optype: OptNone};

  // A record produces the value a source operand wants; x0 never matches
  function automatic logic rec_match(track_rec_t rec, logic [4:0] rs, logic rs_use);
    return rec.valid && (rec.rd != 5'd0) && (rec.rd == rs) && rs_use;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one source operand, plus a flag telling the top whether
// this operand depends on a load still sitting in EX (load-use hazard).
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0]  i_rs_addr,
  input  logic        i_rs_use,
  input  track_rec_t  i_ex_rec,
  input  track_rec_t  i_mem_rec,
  output logic [1:0]  o_fwd_sel,
  output logic        o_ex_load_hit
);

  logic w_ex_match;
  logic w_mem_match;

  assign w_ex_match    = rec_match(i_ex_rec, i_rs_addr, i_rs_use);
  assign w_mem_match   = rec_match(i_mem_rec, i_rs_addr, i_rs_use);
  assign o_ex_load_hit = w_ex_match && (i_ex_rec.optype == OptLoad);

  // Youngest producer wins; a MEM-stage load hands over its load data
  always_comb begin
    o_fwd_sel = FwdRegFile;
    if (w_ex_match) begin
      o_fwd_sel = FwdExAlu;
    end else if (w_mem_match && (i_mem_rec.optype == OptLoad)) begin
      o_fwd_sel = FwdMemLoad;
    end else if (w_mem_match) begin
      o_fwd_sel = FwdMemAlu;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the instructions in EX and MEM, selects
// operand forwarding, stalls on load-use and flushes IF/ID on taken control flow.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic             rs1use,
  input  logic             rs2use,
  input  logic [4:0]       rd_addr,
  input  logic             RegWrite,
  input  logic [1:0]       hazard_optype,
  input  logic             Branch_or_jump,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  track_rec_t       r_ex;
  track_rec_t       r_mem;
  track_rec_t       w_id_rec;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_load_hit_a;
  logic       w_load_hit_b;
  logic       w_stall;
  logic       w_br_flush;

  hazard_fwd_sel u_fwd_a (
    .i_rs_addr     (rs1_addr),
    .i_rs_use      (rs1use),
    .i_ex_rec      (r_ex),
    .i_mem_rec     (r_mem),
    .o_fwd_sel     (w_fwd_a),
    .o_ex_load_hit (w_load_hit_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs_addr     (rs2_addr),
    .i_rs_use      (rs2use),
    .i_ex_rec      (r_ex),
    .i_mem_rec     (r_mem),
    .o_fwd_sel     (w_fwd_b),
    .o_ex_load_hit (w_load_hit_b)
  );

  assign w_stall    = w_load_hit_a || w_load_hit_b;
  // A stalled branch is held in ID and re-evaluated next cycle, so no flush now
  assign w_br_flush = !w_stall && Branch_or_jump;

  assign w_id_rec = '{valid: RegWrite, rd: rd_addr, optype: optype_e'(hazard_optype)};

  // Pipeline enables, flushes and gated forward selects
  always_comb begin
    PC_EN_IF       = 1'b1;
    reg_FD_EN      = 1'b1;
    reg_FD_flush   = 1'b0;
    reg_DE_flush   = 1'b0;
    forward_ctrl_A = w_fwd_a;
    forward_ctrl_B = w_fwd_b;
    if (w_stall) begin
      PC_EN_IF       = 1'b0;
      reg_FD_EN      = 1'b0;
      reg_DE_flush   = 1'b1;
      forward_ctrl_A = FwdRegFile;
      forward_ctrl_B = FwdRegFile;
    end else if (w_br_flush) begin
      reg_FD_flush = 1'b1;
    end
  end

  // Advance the tracking records; a stall pushes a bubble into EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= TrackRecIdle;
      r_mem <= TrackRecIdle;
    end else begin
      r_mem <= r_ex;
      r_ex  <= w_stall ? TrackRecIdle : w_id_rec;
    end
  end

  // Saturating stall / flush event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      if (w_br_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CntOne;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (built with CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [1:0] OpNone = 2'b00, OpAlu = 2'b01, OpLd = 2'b10, OpBr = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_addr, rs2_addr, rd_addr;
  logic          rs1use, rs2use, RegWrite, Branch_or_jump;
  logic [1:0]    hazard_optype;
  logic [1:0]    forward_ctrl_A, forward_ctrl_B;
  logic          PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1use         (rs1use),
    .rs2use         (rs2use),
    .rd_addr        (rd_addr),
    .RegWrite       (RegWrite),
    .hazard_optype  (hazard_optype),
    .Branch_or_jump (Branch_or_jump),
    .forward_ctrl_A (forward_ctrl_A),
    .forward_ctrl_B (forward_ctrl_B),
    .PC_EN_IF       (PC_EN_IF),
    .reg_FD_EN      (reg_FD_EN),
    .reg_FD_flush   (reg_FD_flush),
    .reg_DE_flush   (reg_DE_flush),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one ID-stage instruction
  task automatic id(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                    input logic [4:0] rd, input logic rw, input logic [1:0] op, input logic bj);
    rs1_addr = r1; rs1use = u1; rs2_addr = r2; rs2use = u2;
    rd_addr = rd; RegWrite = rw; hazard_optype = op; Branch_or_jump = bj;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id(0, 0, 0, 0, 0, 0, OpNone, 0);
    tick();
    rst = 1'b0;
  endtask

  // Checks a full control-output snapshot
  task automatic ctl(input string tag, input logic pc, input logic fde, input logic fdf,
                     input logic def, input logic [1:0] fa, input logic [1:0] fb);
    check({tag, ".PC_EN_IF"}, 16'(PC_EN_IF), 16'(pc));
    check({tag, ".reg_FD_EN"}, 16'(reg_FD_EN), 16'(fde));
    check({tag, ".reg_FD_flush"}, 16'(reg_FD_flush), 16'(fdf));
    check({tag, ".reg_DE_flush"}, 16'(reg_DE_flush), 16'(def));
    check({tag, ".fwdA"}, 16'(forward_ctrl_A), 16'(fa));
    check({tag, ".fwdB"}, 16'(forward_ctrl_B), 16'(fb));
  endtask

  initial begin
    rst = 1'b1;
    id(0, 0, 0, 0, 0, 0, OpNone, 0);
    #1;
    // Reset state, checked while rst is still high
    ctl("reset", 1, 1, 0, 0, 2'b00, 2'b00);
    check("reset.stall_cnt", 16'(stall_cnt), 16'h0);
    check("reset.flush_cnt", 16'(flush_cnt), 16'h0);
    tick();
    rst = 1'b0;

    // ADD x5,x1,x2 ; ADD x6,x5,x1 ; ADD x9,x5,x6
    id(1, 1, 2, 1, 5, 1, OpAlu, 0);
    ctl("alu0", 1, 1, 0, 0, 2'b00, 2'b00);
    tick();
    id(5, 1, 1, 1, 6, 1, OpAlu, 0);
    ctl("alu_ex_fwd", 1, 1, 0, 0, 2'b01, 2'b00);
    tick();
    id(5, 1, 6, 1, 9, 1, OpAlu, 0);
    ctl("alu_mem_fwd", 1, 1, 0, 0, 2'b10, 2'b01);

    // LW x5,0(x1) ; ADD x7,x5,x5 -> one stall, then MEM load data both sides
    do_reset();
    id(1, 1, 0, 0, 5, 1, OpLd, 0);
    tick();
    id(5, 1, 5, 1, 7, 1, OpAlu, 0);
    ctl("lu_stall", 0, 0, 0, 1, 2'b00, 2'b00);
    tick();
    ctl("lu_after", 1, 1, 0, 0, 2'b11, 2'b11);
    check("lu.stall_cnt", 16'(stall_cnt), 16'h1);

    // ADDI x0,x0,1 ; ADD x1,x0,x0 -> x0 never forwards
    do_reset();
    id(0, 1, 0, 0, 0, 1, OpAlu, 0);
    tick();
    id(0, 1, 0, 1, 1, 1, OpAlu, 0);
    ctl("x0", 1, 1, 0, 0, 2'b00, 2'b00);

    // LW x3 ; BEQ x3,x4 taken -> stall wins, then flush
    do_reset();
    id(1, 1, 0, 0, 3, 1, OpLd, 0);
    tick();
    id(3, 1, 4, 1, 0, 0, OpBr, 1);
    ctl("br_stall", 0, 0, 0, 1, 2'b00, 2'b00);
    check("br_stall.flush_cnt", 16'(flush_cnt), 16'h0);
    tick();
    ctl("br_flush", 1, 1, 1, 0, 2'b11, 2'b00);
    tick();
    id(0, 0, 0, 0, 0, 0, OpNone, 0);
    check("br.flush_cnt", 16'(flush_cnt), 16'h1);
    check("br.stall_cnt", 16'(stall_cnt), 16'h1);

    // LW x8 (MEM) ; ADD x8 (EX) ; consumer of x8 -> EX priority
    do_reset();
    id(1, 1, 0, 0, 8, 1, OpLd, 0);
    tick();
    id(1, 1, 2, 1, 8, 1, OpAlu, 0);
    tick();
    id(8, 1, 8, 0, 9, 1, OpAlu, 0);
    ctl("ex_prio", 1, 1, 0, 0, 2'b01, 2'b00);

    // LW x5,0(x5) repeated: stalls every other cycle, 19 stalls total
    do_reset();
    id(5, 1, 0, 0, 5, 1, OpLd, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      tick();
      if (i == 14) check("sat.cnt15", 16'(stall_cnt), 16'hF);
    end
    check("sat.stall_cnt", 16'(stall_cnt), 16'hF);
    check("sat.flush_cnt", 16'(flush_cnt), 16'h0);
    tick();
    ctl("pre_rst_stall", 0, 0, 0, 1, 2'b00, 2'b00);
    // Async reset mid-cycle, well before the next rising edge
    #2;
    rst = 1'b1;
    #1;
    ctl("async_rst", 1, 1, 0, 0, 2'b00, 2'b00);
    check("async_rst.stall_cnt", 16'(stall_cnt), 16'h0);
    check("async_rst.flush_cnt", 16'(flush_cnt), 16'h0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
